mem_bank_ctrl_reg: RTL and testbench



---
 rtl/mem_bank_ctrl_reg.sv | 132 +++++++++++++
 tb/tb_mem_bank_ctrl_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_ctrl_reg.sv
// Memory control register with glitch-free bank switching on bits [7:5] (drain, inhibit, settle, commit).
// Define MEM_BANK_PENDING_WRITE_EN to add a one-entry buffer for writes that arrive while a switch is busy.
module mem_bank_ctrl_reg #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  RESET_VALUE   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       mem_active,
    input  logic       err_clr,
    output logic [7:0] ctrl_reg,
    output logic       cs_inhibit,
    output logic       busy,
    output logic       done,
    output logic       wr_err
);

    typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, COMMIT} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [7:0] r_shadow;
    logic [7:0] r_ctrl;
    logic       r_cs_inhibit;
    logic       r_busy;
    logic       r_done;
    logic       r_wr_err;

    logic       w_req;
    logic [7:0] w_req_data;
    logic       w_fast;
    logic       w_switch;
    logic       w_err_set;
    logic       w_inhibit_nxt;
    logic       w_done_nxt;

`ifdef MEM_BANK_PENDING_WRITE_EN
    logic       r_pend_vld;
    logic [7:0] r_pend_data;

    // A buffered write takes priority on return to IDLE; a concurrent external write refills the buffer.
    assign w_req      = (r_state == IDLE) && (r_pend_vld || wr_en);
    assign w_req_data = r_pend_vld ? r_pend_data : wr_data;
    assign w_err_set  = wr_en && r_busy && r_pend_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'h00;
        end else if ((r_state == IDLE) && r_pend_vld) begin
            r_pend_vld <= wr_en;
            if (wr_en) r_pend_data <= wr_data;
        end else if (wr_en && r_busy) begin
            r_pend_vld  <= 1'b1;
            r_pend_data <= wr_data;
        end
    end
`else
    assign w_req      = (r_state == IDLE) && wr_en;
    assign w_req_data = wr_data;
    assign w_err_set  = wr_en && r_busy;
`endif

    assign w_fast   = w_req && (w_req_data[7:5] == r_ctrl[7:5]);
    assign w_switch = w_req && (w_req_data[7:5] != r_ctrl[7:5]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cs_inhibit <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cs_inhibit <= w_inhibit_nxt;
            r_busy       <= w_inhibit_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_switch)      w_state_nxt = DRAIN;
            DRAIN:   if (!mem_active)   w_state_nxt = SETTLE;
            SETTLE:  if (r_cnt == 4'd0) w_state_nxt = COMMIT;
            COMMIT:                     w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_inhibit_nxt = (w_state_nxt != IDLE);
        w_done_nxt    = w_fast || (r_state == COMMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl   <= RESET_VALUE;
            r_shadow <= 8'h00;
            r_cnt    <= 4'd0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_fast)   r_ctrl   <= w_req_data;
            if (w_switch) r_shadow <= w_req_data;

            if ((r_state == DRAIN) && !mem_active) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == SETTLE) begin
                if (r_cnt == 4'd0) r_ctrl <= r_shadow;
                else               r_cnt  <= r_cnt - 4'd1;
            end

            if (w_err_set)    r_wr_err <= 1'b1;
            else if (err_clr) r_wr_err <= 1'b0;
        end
    end

    assign ctrl_reg   = r_ctrl;
    assign cs_inhibit = r_cs_inhibit;
    assign busy       = r_busy;
    assign done       = r_done;
    assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_mem_bank_ctrl_reg.sv
// Directed self-checking bench for mem_bank_ctrl_reg with SETTLE_CYCLES=2.
module tb_mem_bank_ctrl_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       mem_active;
    logic       err_clr;
    logic [7:0] ctrl_reg;
    logic       cs_inhibit;
    logic       busy;
    logic       done;
    logic       wr_err;

    int checks = 0;
    int errors = 0;

    mem_bank_ctrl_reg #(
        .SETTLE_CYCLES(2),
        .RESET_VALUE  (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .mem_active(mem_active),
        .err_clr   (err_clr),
        .ctrl_reg  (ctrl_reg),
        .cs_inhibit(cs_inhibit),
        .busy      (busy),
        .done      (done),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write sampled at the next edge (edge N); returns during cycle N+1.
    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Full switch with mem_active low: commit visible at N+4, release and done at N+5.
    task automatic do_switch(input string tag, input logic [7:0] old_v, input logic [7:0] new_v);
        write(new_v);
        check({tag, " n1 inhibit"}, {7'd0, cs_inhibit}, 8'd1);
        check({tag, " n1 busy"},    {7'd0, busy},       8'd1);
        check({tag, " n1 ctrl"},    ctrl_reg,           old_v);
        tick();
        tick();
        check({tag, " n3 ctrl"},    ctrl_reg,           old_v);
        tick();
        check({tag, " n4 ctrl"},    ctrl_reg,           new_v);
        check({tag, " n4 inhibit"}, {7'd0, cs_inhibit}, 8'd1);
        check({tag, " n4 done"},    {7'd0, done},       8'd0);
        tick();
        check({tag, " n5 inhibit"}, {7'd0, cs_inhibit}, 8'd0);
        check({tag, " n5 busy"},    {7'd0, busy},       8'd0);
        check({tag, " n5 done"},    {7'd0, done},       8'd1);
        tick();
        check({tag, " n6 done"},    {7'd0, done},       8'd0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        check("rst ctrl",    ctrl_reg,           8'h00);
        check("rst inhibit", {7'd0, cs_inhibit}, 8'd0);
        check("rst busy",    {7'd0, busy},       8'd0);
        check("rst wr_err",  {7'd0, wr_err},     8'd0);
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        mem_active = 1'b0;
        err_clr    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("init ctrl",    ctrl_reg,           8'h00);
        check("init inhibit", {7'd0, cs_inhibit}, 8'd0);
        check("init busy",    {7'd0, busy},       8'd0);
        check("init done",    {7'd0, done},       8'd0);
        check("init wr_err",  {7'd0, wr_err},     8'd0);

        // Reset in the middle of DRAIN, asserted between clock edges.
        mem_active = 1'b1;
        write(8'hA0);
        check("drain busy", {7'd0, busy}, 8'd1);
        tick();
        tick();
        pulse_reset();
        mem_active = 1'b0;
        tick();
        check("post rst ctrl", ctrl_reg,     8'h00);
        check("post rst busy", {7'd0, busy}, 8'd0);

        // Switch to bank 1, then fast-path write within bank 1.
        do_switch("sw20", 8'h00, 8'h20);
        write(8'h3F);
        check("fast ctrl",    ctrl_reg,           8'h3F);
        check("fast done",    {7'd0, done},       8'd1);
        check("fast inhibit", {7'd0, cs_inhibit}, 8'd0);
        check("fast busy",    {7'd0, busy},       8'd0);
        tick();
        check("fast done off", {7'd0, done},       8'd0);
        check("fast inh off",  {7'd0, cs_inhibit}, 8'd0);

        do_switch("swE0", 8'h3F, 8'hE0);

        // Drain wait: mem_active high for cycles N+1..N+5.
        pulse_reset();
        mem_active = 1'b1;
        write(8'h40);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("drain c%0d ctrl", i), ctrl_reg, 8'h00);
            check($sformatf("drain c%0d inh", i), {7'd0, cs_inhibit}, 8'd1);
            if (i < 5) tick();
        end
        tick();
        mem_active = 1'b0;
        check("drain c6 ctrl", ctrl_reg, 8'h00);
        tick();
        tick();
        check("drain c8 ctrl", ctrl_reg, 8'h00);
        tick();
        check("drain c9 ctrl", ctrl_reg,           8'h40);
        check("drain c9 inh",  {7'd0, cs_inhibit}, 8'd1);
        tick();
        check("drain c10 inh",  {7'd0, cs_inhibit}, 8'd0);
        check("drain c10 done", {7'd0, done},       8'd1);
        tick();

        // Write while busy: 8'h80 at edge N, 8'hC0 at edge N+2.
        write(8'h80);
        tick();
        write(8'hC0);
`ifdef MEM_BANK_PENDING_WRITE_EN
        check("pend wr_err n3", {7'd0, wr_err}, 8'd0);
        tick();
        check("pend n4 ctrl", ctrl_reg, 8'h80);
        tick();
        check("pend n5 done", {7'd0, done}, 8'd1);
        check("pend n5 busy", {7'd0, busy}, 8'd0);
        tick();
        check("pend n6 busy", {7'd0, busy},       8'd1);
        check("pend n6 inh",  {7'd0, cs_inhibit}, 8'd1);
        tick();
        tick();
        check("pend n8 ctrl", ctrl_reg, 8'h80);
        tick();
        check("pend n9 ctrl", ctrl_reg, 8'hC0);
        tick();
        check("pend n10 done", {7'd0, done}, 8'd1);
        check("pend n10 busy", {7'd0, busy}, 8'd0);
        tick();
        check("pend end ctrl",   ctrl_reg,       8'hC0);
        check("pend end wr_err", {7'd0, wr_err}, 8'd0);
`else
        check("drop wr_err n3", {7'd0, wr_err}, 8'd1);
        check("drop busy n3",   {7'd0, busy},   8'd1);
        tick();
        check("drop n4 ctrl", ctrl_reg, 8'h80);
        tick();
        check("drop n5 done", {7'd0, done}, 8'd1);
        check("drop n5 busy", {7'd0, busy}, 8'd0);
        tick();
        tick();
        check("drop end ctrl",   ctrl_reg,       8'h80);
        check("drop end busy",   {7'd0, busy},   8'd0);
        check("drop end wr_err", {7'd0, wr_err}, 8'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", {7'd0, wr_err}, 8'd0);

        // Error set and err_clr in the same cycle: set wins.
        write(8'h40);
        wr_en   = 1'b1;
        wr_data = 8'hE0;
        err_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        err_clr = 1'b0;
        check("set wins", {7'd0, wr_err}, 8'd1);
        for (int i = 0; i < 4; i++) tick();
        check("set wins ctrl", ctrl_reg,     8'h40);
        check("set wins busy", {7'd0, busy}, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
